// File: rtl/icache_mem_responder_pkg.sv
// Shared cache definitions for the icache line-fill interface.
//   type_icache2mem_s      : icache -> memory request (level req + byte addr)
//   type_mem2icache_s      : memory -> icache response (1-cycle ack + full line)
//   type_imem_resp_state_e : line-fill responder FSM states
// The line width constant ties the response struct to LINE_WORDS*DATA_W;
// responders must be instantiated with matching LINE_WORDS/DATA_W/ADDR_W.
package icache_mem_responder_pkg;

  localparam int IC_LINE_WORDS = 4;
  localparam int IC_DATA_W     = 32;
  localparam int IC_ADDR_W     = 32;
  localparam int IC_LINE_W     = IC_LINE_WORDS * IC_DATA_W;

  typedef struct packed {
    logic                 req;
    logic [IC_ADDR_W-1:0] addr;
  } type_icache2mem_s;

  typedef struct packed {
    logic                 ack;
    logic [IC_LINE_W-1:0] r_data;
  } type_mem2icache_s;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LAST = 3'd2,
    ST_RESP = 3'd3,
    ST_GAP  = 3'd4
  } type_imem_resp_state_e;

endpackage

// File: rtl/icache_mem_responder.sv
// Memory-side responder for icache line fills. Reads a line word-by-word
// from a single-port word-wide SRAM (1-cycle read latency), assembles it in
// a line buffer and returns it with a one-cycle ack.
//
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   imem_sel_i       : responder selected (gates acceptance only)
//   icache2mem_i     : .req (level, held until ack), .addr (byte address)
//   mem2icache_o     : .ack (1-cycle pulse), .r_data (word 0 in LSBs)
//   sram_req_o       : SRAM read strobe
//   sram_addr_o      : word-aligned SRAM byte address
//   sram_rdata_i     : SRAM read data, valid one cycle after the strobe
//
// Build option: IMEM_RESP_CRITICAL_WORD_FIRST_EN -- when defined, reads
// start at the requested word and wrap around the line; otherwise reads
// always start at word 0. Returned line and timing are the same either way.
module icache_mem_responder
  import icache_mem_responder_pkg::*;
#(
  parameter int LINE_WORDS = IC_LINE_WORDS,
  parameter int DATA_W     = IC_DATA_W,
  parameter int ADDR_W     = IC_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               imem_sel_i,
  input  type_icache2mem_s   icache2mem_i,
  output type_mem2icache_s   mem2icache_o,
  output logic               sram_req_o,
  output logic [ADDR_W-1:0]  sram_addr_o,
  input  logic [DATA_W-1:0]  sram_rdata_i
);

  localparam int LW_BITS    = $clog2(LINE_WORDS);
  localparam int LINE_BYTES = LINE_WORDS * 4;

  type_imem_resp_state_e state_q, state_d;
  logic [LW_BITS-1:0]    beat_q, beat_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  alive_q, alive_d;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_q, line_d;
  // Capture slot: the word strobed last cycle lands at cap_idx_q this cycle.
  logic                  cap_vld_q, cap_vld_d;
  logic [LW_BITS-1:0]    cap_idx_q, cap_idx_d;
  logic [LW_BITS-1:0]    word_idx;

`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
  logic [LW_BITS-1:0]    offset_q, offset_d;
  // Power-of-2 line: the adder width gives the mod-LINE_WORDS wrap.
  assign word_idx = offset_q + beat_q;
`else
  assign word_idx = beat_q;
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    alive_d   = alive_q;
    line_d    = line_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
    offset_d  = offset_q;
`endif

    if (cap_vld_q) line_d[cap_idx_q] = sram_rdata_i;

    unique case (state_q)
      ST_IDLE: begin
        if (icache2mem_i.req && imem_sel_i) begin
          state_d = ST_READ;
          beat_d  = '0;
          base_d  = icache2mem_i.addr[ADDR_W-1:0] & ~ADDR_W'(LINE_BYTES - 1);
          alive_d = 1'b1;
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
          offset_d = icache2mem_i.addr[LW_BITS+1:2];
`endif
        end
      end
      ST_READ: begin
        if (!icache2mem_i.req) alive_d = 1'b0;
        cap_vld_d = 1'b1;
        cap_idx_d = word_idx;
        beat_d    = beat_q + 1'b1;
        if (beat_q == LW_BITS'(LINE_WORDS - 1)) state_d = ST_LAST;
      end
      ST_LAST: begin
        if (!icache2mem_i.req) alive_d = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_GAP;
      // GAP swallows a req still high after ack so it cannot start a refill.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      alive_q   <= 1'b0;
      line_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
      offset_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      alive_q   <= alive_d;
      line_q    <= line_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
      offset_q  <= offset_d;
`endif
    end
  end

  // All outputs decode registered state only.
  assign sram_req_o  = (state_q == ST_READ);
  assign sram_addr_o = (state_q == ST_READ) ? (base_q | (ADDR_W'(word_idx) << 2)) : '0;

  assign mem2icache_o.ack    = (state_q == ST_RESP) && alive_q;
  assign mem2icache_o.r_data = line_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Self-checking bench for icache_mem_responder (LINE_WORDS = 4).
// A transaction-level schedule model predicts strobes, addresses, ack and
// line contents every cycle; table vectors and directed sequences add
// explicit end-of-fill checks.
module tb_icache_mem_responder;
  import icache_mem_responder_pkg::*;

  localparam int LW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sel = 1'b0;
  type_icache2mem_s i2m = '0;
  type_mem2icache_s m2i;
  logic             sram_req;
  logic [31:0]      sram_addr;
  logic [31:0]      sram_rdata = 32'h0;

  always #5 clk = ~clk;

  icache_mem_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_sel_i   (sel),
    .icache2mem_i (i2m),
    .mem2icache_o (m2i),
    .sram_req_o   (sram_req),
    .sram_addr_o  (sram_addr),
    .sram_rdata_i (sram_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  // SRAM: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk)
    sram_rdata <= sram_req ? mem_word(sram_addr) : 32'hDEAD_BEEF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: fill schedule in absolute cycle numbers ----
  int          n      = 0;
  bit          m_act  = 0;
  int          m_t    = 0;
  int          m_next = 0;
  bit          m_alive = 0;
  logic [31:0] m_base = '0;
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
  int          m_off  = 0;
`endif

  function automatic int widx(input int k);
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
    return (m_off + k) % LW;
`else
    return k;
`endif
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] b);
    logic [127:0] l;
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = mem_word(b + 32'(4*i));
    return l;
  endfunction

  logic         obs_ack, obs_sreq;
  logic [31:0]  obs_saddr;
  logic [127:0] obs_rdata;

  // One cycle: check outputs against the model, then apply this cycle's inputs.
  task automatic cyc(input logic r, input logic s, input logic [31:0] a, input logic rs);
    int d;
    logic e_req, e_ack;
    logic [31:0] e_addr;
    @(negedge clk);
    obs_ack = m2i.ack; obs_sreq = sram_req; obs_saddr = sram_addr; obs_rdata = m2i.r_data;
    e_req = 0; e_ack = 0; e_addr = '0;
    d = m_act ? n - m_t : -1;
    if (d >= 1 && d <= LW) begin
      e_req  = 1;
      e_addr = m_base + 32'(4 * widx(d - 1));
    end
    if (d == LW + 2) e_ack = m_alive;
    chk("sram_req", obs_sreq, e_req);
    if (e_req) chk("sram_addr", obs_saddr, e_addr);
    chk("ack", obs_ack, e_ack);
    if (e_ack) chk("r_data", obs_rdata, exp_line(m_base));
    rst = rs; sel = s; i2m.req = r; i2m.addr = a;
    if (rs) begin
      m_act = 0; m_next = n + 1;
    end else begin
      if (d >= 1 && d <= LW + 1 && !r) m_alive = 0;
      if (n >= m_next && r && s) begin
        m_act = 1; m_t = n; m_alive = 1; m_next = n + LW + 4;
        m_base = a & ~32'(LW*4 - 1);
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
        m_off = int'(a[3:2]);
`endif
      end
    end
    n++;
  endtask

  typedef struct {
    logic [31:0]  addr;
    int           hold;      // req high in cycles T .. T+hold-1
    logic         exp_ack;
    logic [127:0] exp_line;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] ord [4];
  logic [31:0] sa  [4];
  int acks, ack_at, strobes, k;
  logic [127:0] line;
  logic rq;

  initial begin
    tbl[0] = '{32'h0000_1008, 7, 1'b1, {32'hA500_100C, 32'hA500_1008, 32'hA500_1004, 32'hA500_1000}};
    tbl[1] = '{32'h0000_1000, 2, 1'b0, 128'h0};
    tbl[2] = '{32'h0000_2000, 7, 1'b1, {32'hA500_200C, 32'hA500_2008, 32'hA500_2004, 32'hA500_2000}};
    tbl[3] = '{32'h0000_3FFE, 8, 1'b1, {32'hA500_3FFC, 32'hA500_3FF8, 32'hA500_3FF4, 32'hA500_3FF0}};
    tbl[4] = '{32'h0000_0FF4, 4, 1'b0, 128'h0};
    tbl[5] = '{32'h0000_0040, 6, 1'b1, {32'hA500_004C, 32'hA500_0048, 32'hA500_0044, 32'hA500_0040}};
    tbl[6] = '{32'h0000_0044, 5, 1'b0, 128'h0};
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
    ord = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
`else
    ord = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
`endif

    // Reset held, then first cycle after release.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 32'h0, i < 3);
      chk("rst_ack", obs_ack, 1'b0);
      chk("rst_rdata", obs_rdata, 128'h0);
      chk("rst_sreq", obs_sreq, 1'b0);
      chk("rst_saddr", obs_saddr, 32'h0);
    end

    // Table vectors: one request each, 10 cycles.
    for (int v = 0; v < 7; v++) begin
      acks = 0; ack_at = -1; strobes = 0; line = '0;
      for (int i = 0; i < 10; i++) begin
        cyc(i < tbl[v].hold, 1'b1, (i == 0) ? tbl[v].addr : 32'h0000_7770 + 32'(i), 1'b0);
        if (obs_ack) begin acks++; ack_at = i; line = obs_rdata; end
        if (obs_sreq) strobes++;
      end
      chk("tbl_acks", 128'(acks), 128'(tbl[v].exp_ack));
      chk("tbl_strobes", 128'(strobes), 128'(LW));
      if (tbl[v].exp_ack) begin
        chk("tbl_ack_cycle", 128'(ack_at), 128'(6));
        chk("tbl_line", line, tbl[v].exp_line);
      end
    end

    // Strobe order for addr 0x1008.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i < 7, 1'b1, (i == 0) ? 32'h1008 : 32'h0, 1'b0);
      if (obs_sreq && k < 4) begin sa[k] = obs_saddr; k++; end
    end
    chk("order_cnt", 128'(k), 128'(4));
    for (int j = 0; j < 4; j++) chk("order_addr", sa[j], ord[j]);

    // Abort at T+2, new request at T+8 acks at T+14.
    acks = 0; ack_at = -1; strobes = 0; line = '0;
    for (int i = 0; i < 17; i++) begin
      cyc((i < 2) || (i >= 8 && i < 15), 1'b1, (i < 8) ? 32'h1000 : 32'h2000, 1'b0);
      if (obs_ack) begin acks++; ack_at = i; line = obs_rdata; end
      if (obs_sreq) strobes++;
    end
    chk("abort_acks", 128'(acks), 128'(1));
    chk("abort_ack_cycle", 128'(ack_at), 128'(14));
    chk("abort_strobes", 128'(strobes), 128'(8));
    chk("abort_line", line, {32'hA500_200C, 32'hA500_2008, 32'hA500_2004, 32'hA500_2000});

    // Not selected: no strobe.
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 32'h3000, 1'b0);
      if (obs_sreq) strobes++;
    end
    cyc(1'b0, 1'b1, 32'h0, 1'b0);
    chk("unsel_strobes", 128'(strobes), 128'(0));

    // Reset at T+3 of a fill.
    acks = 0; strobes = 0;
    for (int i = 0; i < 11; i++) begin
      cyc(i < 3, 1'b1, 32'h5000, i == 3);
      if (i >= 4 && obs_sreq) strobes++;
      if (obs_ack) acks++;
    end
    chk("midrst_strobes", 128'(strobes), 128'(0));
    chk("midrst_acks", 128'(acks), 128'(0));

    // Randomized traffic against the schedule model.
    rq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rq = ~rq;
      cyc(rq, $urandom_range(0, 4) != 0, 32'($urandom_range(0, 32'hFFFF)),
          $urandom_range(0, 199) == 0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_mem_responder.md
# icache_mem_responder

Memory-side responder for the instruction-cache line-fill interface. It accepts a line-fill request from the icache, reads the line word-by-word from a single-port, word-wide instruction SRAM, and assembles the words into a cache line. It then returns the full line with a one-cycle ack. It sits between `icache_top`'s memory port and the instruction SRAM/ROM macro.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per cache line; must be a power of 2 and at least 2.
- `DATA_W`, default 32: SRAM word width.
- `ADDR_W`, default 32: byte-address width.
- `clk_i  in  1`: clock.
- `rst_i  in  1`: reset, synchronous, active-high.
- `imem_sel_i  in  1`: responder selected; gates acceptance of new requests only.
- `icache2mem_i  in  type_icache2mem_s`: `.req` (level, held until ack) and `.addr` (byte address).
- `mem2icache_o  out  type_mem2icache_s`: `.ack` (1-cycle pulse) and `.r_data` (`LINE_WORDS*DATA_W` bits, word 0 in the LSBs).
- `sram_req_o  out  1`: SRAM read strobe.
- `sram_addr_o  out  ADDR_W`: word-aligned byte address (bits [1:0] = 0).
- `sram_rdata_i  in  DATA_W`: read data, valid exactly 1 cycle after the strobe.

## Operation
- States:
  - IDLE: waiting for a request.
  - READ: issuing SRAM reads.
  - LAST: capturing the final word.
  - RESP: presenting the line and ack.
  - GAP: one-cycle hold-off after RESP.
- IDLE -> READ when `req && imem_sel_i`.
  - Latch the line base: addr with the low log2(LINE_WORDS*4) bits cleared.
  - Latch the word offset addr[log2(LINE_WORDS)+1:2].
  - Clear the `alive` flag's complement, i.e. set `alive` = 1.
- READ lasts LINE_WORDS cycles.
  - `sram_req_o` = 1 in every READ cycle.
  - A beat counter (log2(LINE_WORDS) bits) increments once per cycle.
  - `sram_addr_o` = base + 4*word_index.
  - Each returned word is written into the line buffer at its own word index on the following cycle. Data is never shifted.
- LAST lasts 1 cycle: `sram_req_o` = 0 and the final word is captured.
- RESP lasts 1 cycle: `ack` = `alive`, and `r_data` = the line buffer.
- GAP lasts 1 cycle: `req` is ignored, then the FSM returns to IDLE. This prevents a second fill from a `req` still high the cycle after ack.
- Request dropped before completion:
  - If `req` is sampled low in any READ or LAST cycle, `alive` is cleared.
  - The SRAM sequence still completes and no ack is issued.
- `imem_sel_i` falling mid-fill has no effect on the fill in progress.
- The `addr` input is ignored after acceptance.
- `r_data` holds the last assembled line between fills. It is meaningful only while `ack` = 1.

## Timing
- Reset values:
  - state = IDLE
  - `ack` = 0
  - `r_data` = 0
  - `sram_req_o` = 0
  - `sram_addr_o` = 0
  - beat counter = 0
  - `alive` = 0
- Reset asserted mid-fill: all reset values apply on the next edge, and no ack follows.
- Request sampled in IDLE at cycle T:
  - SRAM strobes in cycles T+1 .. T+LINE_WORDS.
  - `ack` in cycle T+LINE_WORDS+2 (T+6 for the default).
  - GAP in cycle T+LINE_WORDS+3.
  - Earliest next acceptance at T+LINE_WORDS+4.
- Throughput: one line per LINE_WORDS+4 cycles.
- `ack` and `r_data` are driven from registers; there is no combinational path from input to output.

## Configuration
- Macro `IMEM_RESP_CRITICAL_WORD_FIRST_EN`.
- Defined: word_index = (offset + beat) mod LINE_WORDS, so reads start at the requested word and wrap around the line.
- Undefined: word_index = beat, so reads always start at word 0 and offset is unused.
- The returned line, the ack cycle and the latency are identical in both builds. Only the SRAM address order differs.

## Structure
- The shared cache package (`cache_defs.svh`) carries:
  - `type_icache2mem_s` and `type_mem2icache_s`;
  - the line-width constant tied to LINE_WORDS*DATA_W;
  - the new enum `type_imem_resp_state_e`.
- Single module, no sub-module. The SRAM macro is external.

## Test plan
- Reset check: hold `rst_i` for 3 cycles -> `ack` = 0, `r_data` = 0, `sram_req_o` = 0 and `sram_addr_o` = 0 while reset is held and on the first cycle after release.
- Basic fill, macro off:
  - Preload SRAM word at byte address A with 0xA5000000 | A.
  - Request `addr` 0x0000_1008 at T.
  - Expect strobes at 0x1000, 0x1004, 0x1008, 0x100C in T+1..T+4.
  - Expect `ack` only at T+6 with `r_data` = {0xA500100C, 0xA5001008, 0xA5001004, 0xA5001000}.
- Critical word first, macro on, same request:
  - Expect strobe order 0x1008, 0x100C, 0x1000, 0x1004.
  - Expect an identical `r_data` and ack at T+6.
- Abort:
  - Request 0x1000, then drop `req` at T+2 -> four strobes still occur and no `ack` is issued.
  - A new request for 0x2000 at T+8 -> `ack` at T+14 with line 0x2000.
- Held request: keep `req` high for 12 cycles after T -> exactly one fill and exactly one ack pulse, with no strobe in the GAP cycle.
- Selection and reset:
  - `req` = 1 with `imem_sel_i` = 0 for 10 cycles -> no strobe.
  - Reset at T+3 of a fill -> IDLE, no ack, and `sram_req_o` = 0 from T+4.
